// File: rtl/branch_resolve_unit.sv
// Branch condition resolver (BEQ/BNE/BLT/BGE/BLTU/BGEU) with a bimodal 2-bit BHT.
// Optional statistics counters are compiled in with `define BRANCH_STATS_EN.
module branch_resolve_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned BHT_DEPTH  = 16,
  parameter logic [1:0]  BHT_INIT   = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PC_WIDTH-1:0]   predict_pc,
  output logic                  predict_taken,
  input  logic                  resolve_valid,
  input  logic [PC_WIDTH-1:0]   resolve_pc,
  input  logic [2:0]            resolve_cond_type,
  input  logic [DATA_WIDTH-1:0] resolve_data_1,
  input  logic [DATA_WIDTH-1:0] resolve_data_2,
  input  logic                  resolve_pred_taken,
  input  logic                  flush,
  output logic                  result_valid,
  output logic                  condition_satisfied,
  output logic                  mispredict
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  localparam logic [2:0] CT_BEQ  = 3'd1;
  localparam logic [2:0] CT_BNE  = 3'd2;
  localparam logic [2:0] CT_BLT  = 3'd3;
  localparam logic [2:0] CT_BGE  = 3'd4;
  localparam logic [2:0] CT_BLTU = 3'd5;
  localparam logic [2:0] CT_BGEU = 3'd6;

  // Handshake: a request is accepted on any rising edge with resolve_valid=1 and
  // flush=0; there is no ready. Its result is held for exactly the next cycle.
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic             accept;
  logic             is_branch;
  logic             eq;
  logic             lt_s;
  logic             lt_u;
  logic             taken;
  logic             miss;

  assign pred_idx  = predict_pc[IDX_W+1:2];
  assign res_idx   = resolve_pc[IDX_W+1:2];
  assign accept    = resolve_valid & ~flush;
  assign is_branch = (resolve_cond_type != 3'd0) && (resolve_cond_type != 3'd7);

  // Only the index field of the PCs is used; the rest aliases by design.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{predict_pc, resolve_pc};

  assign eq   = (resolve_data_1 == resolve_data_2);
  assign lt_s = $signed(resolve_data_1) < $signed(resolve_data_2);
  assign lt_u = resolve_data_1 < resolve_data_2;

  always_comb begin
    taken = 1'b0;
    case (resolve_cond_type)
      CT_BEQ:  taken = eq;
      CT_BNE:  taken = ~eq;
      CT_BLT:  taken = lt_s;
      CT_BGE:  taken = ~lt_s;
      CT_BLTU: taken = lt_u;
      CT_BGEU: taken = ~lt_u;
      default: taken = 1'b0;
    endcase
  end

  assign miss = taken ^ resolve_pred_taken;

  // Result registers
  logic result_valid_q, result_valid_d;
  logic cond_q, cond_d;
  logic mispredict_q, mispredict_d;

  always_comb begin
    result_valid_d = accept;
    cond_d         = accept & taken;
    mispredict_d   = accept & miss;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_valid_q <= 1'b0;
      cond_q         <= 1'b0;
      mispredict_q   <= 1'b0;
    end else begin
      result_valid_q <= result_valid_d;
      cond_q         <= cond_d;
      mispredict_q   <= mispredict_d;
    end
  end

  assign result_valid        = result_valid_q;
  assign condition_satisfied = cond_q;
  assign mispredict          = mispredict_q;

  // Branch history table; the read port sees the pre-update value (no bypass).
  logic [1:0] bht_q [BHT_DEPTH];
  logic [1:0] ctr_cur;
  logic [1:0] ctr_d;

  assign ctr_cur       = bht_q[res_idx];
  assign predict_taken = bht_q[pred_idx][1];

  always_comb begin
    ctr_d = ctr_cur;
    if (taken) begin
      if (ctr_cur != 2'd3) ctr_d = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'd0) ctr_d = ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= BHT_INIT;
    end else if (accept && is_branch) begin
      bht_q[res_idx] <= ctr_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (accept && is_branch) begin
      if (stat_branches_q != 32'hFFFF_FFFF) stat_branches_d = stat_branches_q + 32'd1;
      if (miss && (stat_mispredicts_q != 32'hFFFF_FFFF))
        stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches_q    <= 32'd0;
      stat_mispredicts_q <= 32'd0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Parametrised branch condition resolver with an integrated bimodal branch history table (BHT).
- Replaces the single-cycle BEQ/BNE checker.
- Supports signed and unsigned compares.
- Registers the resolution result and flags mispredicts back to the IF stage.
- Trains a table of 2-bit saturating counters.
- Sits at the ID/EX boundary; the predict port is read by IF.

Parameters:
DATA_WIDTH, 32, operand width for the compare
PC_WIDTH, 32, program counter width
BHT_DEPTH, 16, number of BHT entries; power of 2, minimum 2
BHT_INIT, 2'b01, reset value of every counter (weakly not-taken)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous reset, active low
predict_pc  input  PC_WIDTH  PC of the instruction being fetched
predict_taken  output  1  combinational; MSB of BHT[index(predict_pc)]
resolve_valid  input  1  resolve request this cycle
resolve_pc  input  PC_WIDTH  PC of the branch being resolved
resolve_cond_type  input  3  0 NONE, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 reserved (treated as NONE)
resolve_data_1  input  DATA_WIDTH  register operand rs
resolve_data_2  input  DATA_WIDTH  register operand rt
resolve_pred_taken  input  1  prediction IF made for this branch
flush  input  1  kill the request presented this cycle
result_valid  output  1  registered result is valid
condition_satisfied  output  1  registered; branch taken
mispredict  output  1  registered; condition_satisfied != pred_taken

Behaviour:
- Index: idx(pc) = pc[log2(BHT_DEPTH)+1 : 2], word-aligned; upper bits are ignored (aliasing is allowed).
- Reset (rst_n=0 at a rising edge):
  - result_valid, condition_satisfied and mispredict go to 0.
  - All BHT entries go to BHT_INIT.
  - Resolve inputs in that cycle are discarded.
  - Reset mid-stream drops any in-flight result.
- Compare, combinational in the request cycle:
  - eq = (d1 == d2).
  - lt_s = $signed(d1) < $signed(d2).
  - lt_u = d1 < d2.
  - BEQ=eq, BNE=~eq, BLT=lt_s, BGE=~lt_s, BLTU=lt_u, BGEU=~lt_u.
  - NONE and 7 give 0.
- Latency: exactly 1 cycle. A request at edge N (resolve_valid=1, flush=0) produces result_valid=1 during cycle N+1 with that request's outputs.
- No request, or flush=1: next cycle result_valid=0, condition_satisfied=0, mispredict=0.
- No backpressure; a new request is accepted every cycle.
- mispredict = taken XOR resolve_pred_taken, for all types. NONE with pred_taken=1 reports mispredict=1, which recovers a bogus predicted jump.
- BHT update at the same edge, only if resolve_valid=1, flush=0, and type is in 1..6:
  - taken: ctr = (ctr==3) ? 3 : ctr+1.
  - not taken: ctr = (ctr==0) ? 0 : ctr-1.
  - Counters saturate; they never wrap.
- Read/write same index in the same cycle: predict_taken shows the pre-update value. The new value is visible from the following cycle (no bypass).
- NONE/reserved types never modify the BHT.

Optional Feature:
Macro BRANCH_STATS_EN.
- Defined:
  - Extra outputs stat_branches [31:0] and stat_mispredicts [31:0].
  - stat_branches counts accepted type 1..6 requests; stat_mispredicts counts those that mispredicted.
  - Counters are registered, clear on reset, and saturate at 32'hFFFF_FFFF.
  - Updates are visible the cycle after the request, aligned with result_valid.
- Not defined: neither port nor any counter logic exists. All other behaviour is identical.

Test Plan:
- Reset, then predict_pc=0x0040 → predict_taken=0 for all 16 indices; result_valid=0.
- BLT d1=0xFFFFFFFF, d2=1, pred=0 → next cycle result_valid=1, cond=1, mispredict=1.
- BLTU with the same operands, pred=0 → cond=0, mispredict=0.
- Saturation at pc=0x0008:
  - Three taken BEQ (d1=d2=5) give ctr 1→2→3→3; predict_taken=1 from the cycle after the first update.
  - Three not-taken BEQ (d1=5, d2=6) then give ctr 3→2→1→0; predict_taken=0 after the second.
- Flush: BNE d1=1, d2=2 with flush=1 → next cycle result_valid=0. BHT[idx] is unchanged, checked by reading predict_pc=same.
- Same-cycle conflict and NONE handling:
  - predict_pc=resolve_pc=0x0010 with ctr=1 and a taken BGE (d1=7, d2=7): predict_taken=0 that cycle, 1 the next.
  - NONE type with pred=1 → mispredict=1 and BHT unchanged.
  - With BRANCH_STATS_EN: stat_branches increments only for the BGE, not the NONE.
